keypad_scanner: RTL and testbench

//  Drives and reads the 4x4 push-button matrix, then debounces and validates a single press.

---
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: drives one row at a time, synchronises the columns,
// debounces a single one-hot press and reports it as a strobe plus {row,col} key code.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       strobe,
    output logic [7:0] cur_key,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       ROW_FIRST = 4'b1000;
    localparam bit               DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_SAT) ? v : v + CNT_ONE;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       scol_q;
    logic [3:0]       row_q, row_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       cur_key_q, cur_key_d;
    logic             strobe_q, strobe_d;
    logic             key_held_q, key_held_d;

    logic             scan_done;
    logic             scol_zero;
    logic             scol_onehot;
    logic             deb_match;
    logic             deb_done;
    logic             rel_done;
    logic             accept;
    logic [3:0]       row_next;

    // Column synchroniser; col is asynchronous to clk.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 4'b0000;
            scol_q  <= 4'b0000;
        end else begin
            sync1_q <= col;
            scol_q  <= sync1_q;
        end
    end

    always_comb begin
        scan_done   = (scan_cnt_q >= SCAN_LAST);
        scol_zero   = (scol_q == 4'b0000);
        scol_onehot = !scol_zero && ((scol_q & (scol_q - 4'b0001)) == 4'b0000);
        deb_match   = ({row_q, scol_q} == cand_q);
        deb_done    = deb_match && (deb_cnt_q >= DEB_LAST);
        rel_done    = scol_zero && (rel_cnt_q >= DEB_LAST);
        row_next    = {row_q[0], row_q[3:1]};
        accept      = ((state_q == SCAN) && scan_done && scol_onehot && DEB_SINGLE)
                   || ((state_q == DEBOUNCE) && deb_done);
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (scan_done && scol_onehot) begin
                    state_d = DEB_SINGLE ? HOLD : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!deb_match) begin
                    state_d = SCAN;
                end else if (deb_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rel_done) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        row_d      = row_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        cand_d     = cand_q;
        cur_key_d  = cur_key_q;
        strobe_d   = 1'b0;
        key_held_d = key_held_q;

        unique case (state_q)
            SCAN: begin
                if (scan_done) begin
                    scan_cnt_d = '0;
                    if (scol_onehot) begin
                        cand_d    = {row_q, scol_q};
                        deb_cnt_d = CNT_ONE;
                    end else begin
                        row_d = row_next;
                    end
                end else begin
                    scan_cnt_d = sat_inc(scan_cnt_q);
                end
            end
            DEBOUNCE: begin
                if (deb_match) begin
                    deb_cnt_d = sat_inc(deb_cnt_q);
                end else begin
                    scan_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!scol_zero) begin
                    rel_cnt_d = '0;
                end else if (rel_done) begin
                    rel_cnt_d  = '0;
                    key_held_d = 1'b0;
                    row_d      = row_next;
                    scan_cnt_d = '0;
                end else begin
                    rel_cnt_d = sat_inc(rel_cnt_q);
                end
            end
            default: begin
                row_d      = ROW_FIRST;
                scan_cnt_d = '0;
            end
        endcase

        // While debouncing, a match means {row,scol} already equals the candidate.
        if (accept) begin
            cur_key_d  = {row_q, scol_q};
            strobe_d   = 1'b1;
            key_held_d = 1'b1;
            rel_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            row_q      <= ROW_FIRST;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            cand_q     <= 8'h00;
            cur_key_q  <= 8'h00;
            strobe_q   <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            cand_q     <= cand_d;
            cur_key_q  <= cur_key_d;
            strobe_q   <= strobe_d;
            key_held_q <= key_held_d;
        end
    end

    assign row      = row_q;
    assign strobe   = strobe_q;
    assign cur_key  = cur_key_q;
    assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical 4x4 keypad model drives col from row,
// and press-level expectations (key code, strobe count, latency bounds) are checked.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int MAX_LAT  = 2 + 4 * SCAN_DIV + DEB + 1;

    logic       clk = 1'b0;
    logic       nRst;
    logic [3:0] col;
    logic [3:0] row;
    logic       strobe;
    logic [7:0] cur_key;
    logic       key_held;

    logic [15:0] pressed;
    logic        col_ovr_en;
    logic [3:0]  col_ovr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int strobe_cnt  = 0;
    int last_strobe_cyc = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_key = 8'h00;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .col      (col),
        .row      (row),
        .strobe   (strobe),
        .cur_key  (cur_key),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] base;
        base = 4'b1000;
        return base >> i;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] k;
        k = 16'h0000;
        k[r * 4 + c] = 1'b1;
        return k;
    endfunction

    function automatic logic [7:0] exp_key(input int r, input int c);
        return {onehot(r), onehot(c)};
    endfunction

    // Physical matrix: a pressed key connects its row line to its column line.
    always_comb begin
        col = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && (row == onehot(r))) col = col | onehot(c);
            end
        end
        if (col_ovr_en) col = col_ovr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Continuous monitor: strobe bookkeeping and per-cycle invariants.
    always @(negedge clk) begin
        if (nRst === 1'b1) begin
            check("row_onehot", 32'($onehot(row)), 32'd1);
            if (strobe === 1'b1) begin
                strobe_cnt      = strobe_cnt + 1;
                last_strobe_cyc = cyc;
                check("strobe_single_cycle", 32'(prev_strobe), 32'd0);
                check("key_held_at_strobe", 32'(key_held), 32'd1);
            end
            if (cur_key !== prev_key) check("key_change_only_on_strobe", 32'(strobe), 32'd1);
            prev_strobe = strobe;
        end else begin
            prev_strobe = 1'b0;
        end
        prev_key = cur_key;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int p;
        int stop;
        int r;
        int c;
        int c2;
        int hold;
        int changes;
        int since;
        logic [3:0] last_row;

        // 1. Reset with all columns high.
        pressed    = 16'h0000;
        col_ovr_en = 1'b1;
        col_ovr    = 4'b1111;
        nRst       = 1'b0;
        tick(3);
        check("t1_row", 32'(row), 32'h8);
        check("t1_strobe", 32'(strobe), 32'd0);
        check("t1_cur_key", 32'(cur_key), 32'h00);
        check("t1_key_held", 32'(key_held), 32'd0);
        col_ovr_en = 1'b0;
        nRst       = 1'b1;
        base = strobe_cnt;
        tick(40);
        check("t1_no_strobe_idle", 32'(strobe_cnt - base), 32'd0);

        // 2. Clean press R2C0, then release.
        base = strobe_cnt;
        pressed = key_bit(2, 0);
        p = cyc;
        tick(40);
        check("t2_strobes", 32'(strobe_cnt - base), 32'd1);
        check("t2_cur_key", 32'(cur_key), 32'h28);
        check("t2_key_held", 32'(key_held), 32'd1);
        check("t2_latency_ok", 32'((last_strobe_cyc - p) <= MAX_LAT), 32'd1);
        pressed = 16'h0000;
        tick(DEB - 1);
        check("t2_held_before_release_debounced", 32'(key_held), 32'd1);
        tick(5);
        check("t2_released", 32'(key_held), 32'd0);
        check("t2_key_kept", 32'(cur_key), 32'h28);
        tick(10);

        // 3. Bouncing R3C0, then steady.
        base = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? key_bit(3, 0) : 16'h0000;
            tick(3);
        end
        pressed = key_bit(3, 0);
        stop = cyc;
        tick(60);
        check("t3_strobes", 32'(strobe_cnt - base), 32'd1);
        check("t3_cur_key", 32'(cur_key), 32'h18);
        check("t3_after_bounce", 32'((last_strobe_cyc - stop) >= DEB), 32'd1);
        check("t3_latency_ok", 32'((last_strobe_cyc - stop) <= MAX_LAT), 32'd1);
        pressed = 16'h0000;
        tick(14);
        check("t3_released", 32'(key_held), 32'd0);

        // 4. Ghost / multi-key in R1: no strobe, scanning continues at a steady rate.
        base = strobe_cnt;
        pressed = key_bit(1, 0) | key_bit(1, 2);
        last_row = row;
        changes = 0;
        since = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            since++;
            if (row !== last_row) begin
                if (changes > 0) check("t4_row_period", 32'(since), 32'(SCAN_DIV));
                changes++;
                since = 0;
                last_row = row;
            end
        end
        check("t4_no_strobe", 32'(strobe_cnt - base), 32'd0);
        check("t4_scanning", 32'(changes >= 64 / SCAN_DIV - 1), 32'd1);
        pressed = 16'h0000;
        tick(10);

        // 5. Same key twice, second press held long: no auto-repeat.
        base = strobe_cnt;
        pressed = key_bit(2, 2);
        tick(40);
        check("t5_first_strobe", 32'(strobe_cnt - base), 32'd1);
        check("t5_first_key", 32'(cur_key), 32'h22);
        pressed = 16'h0000;
        tick(20);
        check("t5_released", 32'(key_held), 32'd0);
        pressed = key_bit(2, 2);
        tick(200);
        check("t5_two_strobes", 32'(strobe_cnt - base), 32'd2);
        check("t5_second_key", 32'(cur_key), 32'h22);
        pressed = 16'h0000;
        tick(20);

        // Randomized single presses with optional bounce and a same-row second key during hold.
        for (int n = 0; n < 12; n++) begin
            base = strobe_cnt;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            c2 = (c + 1 + int'($urandom_range(0, 2))) % 4;
            repeat ($urandom_range(0, 3)) begin
                pressed = key_bit(r, c);
                tick(int'($urandom_range(1, 2)));
                pressed = 16'h0000;
                tick(int'($urandom_range(1, 2)));
            end
            pressed = key_bit(r, c);
            p = cyc;
            hold = int'($urandom_range(45, 80));
            tick(30);
            if ($urandom_range(0, 1) == 1) begin
                pressed = key_bit(r, c) | key_bit(r, c2);
                tick(10);
                pressed = key_bit(r, c);
            end else begin
                tick(10);
            end
            tick(hold - 40);
            check("rnd_strobes", 32'(strobe_cnt - base), 32'd1);
            check("rnd_cur_key", 32'(cur_key), 32'(exp_key(r, c)));
            check("rnd_latency_ok", 32'((last_strobe_cyc - p) <= MAX_LAT), 32'd1);
            check("rnd_key_held", 32'(key_held), 32'd1);
            pressed = 16'h0000;
            tick(int'($urandom_range(14, 30)));
            check("rnd_released", 32'(key_held), 32'd0);
        end

        // 6. Reset in the middle of debouncing R0C3.
        nRst = 1'b0;
        pressed = key_bit(0, 3);
        tick(2);
        base = strobe_cnt;
        nRst = 1'b1;
        tick(8);
        check("t6_no_strobe_yet", 32'(strobe_cnt - base), 32'd0);
        nRst = 1'b0;
        #1;
        check("t6_row", 32'(row), 32'h8);
        check("t6_strobe", 32'(strobe), 32'd0);
        check("t6_cur_key", 32'(cur_key), 32'h00);
        check("t6_key_held", 32'(key_held), 32'd0);
        pressed = 16'h0000;
        tick(2);
        nRst = 1'b1;
        check("t6_restart_r0", 32'(row), 32'h8);
        tick(SCAN_DIV - 1);
        check("t6_r0_still", 32'(row), 32'h8);
        tick(1);
        check("t6_r1_next", 32'(row), 32'h4);
        tick(40);
        check("t6_no_strobe", 32'(strobe_cnt - base), 32'd0);
        check("t6_key_cleared", 32'(cur_key), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
